seg7_scan_driver: RTL and testbench

Parametrised multiplexed driver for a multi-digit common-anode/cathode 7-segment display. It latches a packed BCD word, scans one digit at a time at a programmable rate, and drives shared segment lines plus per-digit enables. Optional leading-zero blanking and an error glyph for non-decimal nibbles are included. It sits between the counter/datapath logic and the board's display pins, and generalises the single-digit decimal-to-segment decoder.

---
 rtl/seg7_scan_driver_if.sv | 29 ++
 rtl/seg7_scan_driver.sv | 132 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display-driver bus: groups the snapshot/control inputs and display-pin
// outputs of seg7_scan_driver.
//   bcd_in     : packed BCD word, digit i at [4i+3:4i], digit 0 least significant
//   load       : capture bcd_in into the snapshot register at the next edge
//   enable     : low blanks the display and freezes scanning
//   segments   : {a,b,c,d,e,f,g}, polarity set by the driver
//   digit_sel  : one-hot digit enable, polarity set by the driver
//   frame_done : one-cycle pulse when the last digit's slot ends
// master = the logic feeding the display, slave = the driver itself.
interface seg7_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd_in;
    logic                load;
    logic                enable;
    logic [6:0]          segments;
    logic [DIGITS-1:0]   digit_sel;
    logic                frame_done;

    modport master (
        output bcd_in, load, enable,
        input  segments, digit_sel, frame_done
    );

    modport slave (
        input  bcd_in, load, enable,
        output segments, digit_sel, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed multi-digit 7-segment scan driver.
// Latches a packed BCD word, lights one digit at a time for TICKS_PER_DIGIT
// cycles, decodes each nibble to abcdefg (non-decimal nibbles show 'E') and
// optionally blanks leading zeros. All outputs are registered.
// Ports:
//   clk_i : system clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : seg7_scan_driver_if slave (bcd_in/load/enable in,
//           segments/digit_sel/frame_done out)
module seg7_scan_driver #(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned TICKS_PER_DIGIT = 50000,
    parameter bit          SEG_ACTIVE_LOW  = 1'b0,
    parameter bit          DIG_ACTIVE_LOW  = 1'b1,
    parameter bit          BLANK_LEADING   = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    seg7_scan_driver_if.slave   bus
);

    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PreW = $clog2(TICKS_PER_DIGIT);

    localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);
    localparam logic [PreW-1:0] PreLast = PreW'(TICKS_PER_DIGIT - 1);

    // Pin levels for "everything dark"
    localparam logic [6:0]        SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DigOff = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [PreW-1:0]     presc_q, presc_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                frame_q, frame_d;

    logic [3:0]          cur_nib;
    logic                cur_blank;
    logic [DIGITS-1:0]   onehot;
    logic [DIGITS:0]     zero_above;  // [i]: digit i and every higher digit are zero
    logic [6:0]          seg_raw;

    // Current digit selection and leading-zero detection (active-high)
    always_comb begin
        cur_nib            = 4'h0;
        cur_blank          = 1'b0;
        onehot             = '0;
        zero_above         = '0;
        zero_above[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] && (snap_q[4*i +: 4] == 4'h0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            onehot[i] = (idx_q == IdxW'(i));
            if (idx_q == IdxW'(i)) begin
                cur_nib   = snap_q[4*i +: 4];
                cur_blank = BLANK_LEADING && (i > 0) && zero_above[i];
            end
        end
    end

    // Nibble to abcdefg, bit6 = a
    always_comb begin
        seg_raw = 7'b1001111;  // 'E' for 10..15
        case (cur_nib)
            4'd0:    seg_raw = 7'b1111110;
            4'd1:    seg_raw = 7'b0110000;
            4'd2:    seg_raw = 7'b1101101;
            4'd3:    seg_raw = 7'b1111001;
            4'd4:    seg_raw = 7'b0110011;
            4'd5:    seg_raw = 7'b1011011;
            4'd6:    seg_raw = 7'b1011111;
            4'd7:    seg_raw = 7'b1110000;
            4'd8:    seg_raw = 7'b1111111;
            4'd9:    seg_raw = 7'b1110011;
            default: seg_raw = 7'b1001111;
        endcase
        if (cur_blank) begin
            seg_raw = 7'b0000000;
        end
    end

    // Next state: prescaler/index advance and registered pin values
    always_comb begin
        snap_d  = bus.load ? bus.bcd_in : snap_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        seg_d   = SegOff;
        dig_d   = DigOff;
        frame_d = 1'b0;
        if (bus.enable) begin
            seg_d = seg_raw ^ {7{SEG_ACTIVE_LOW}};
            dig_d = onehot ^ {DIGITS{DIG_ACTIVE_LOW}};
            if (presc_q == PreLast) begin
                presc_d = '0;
                if (idx_q == IdxLast) begin
                    idx_d   = '0;
                    frame_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SegOff;
            dig_q   <= DigOff;
            frame_q <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
        end
    end

    assign bus.segments   = seg_q;
    assign bus.digit_sel  = dig_q;
    assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: two instances (normal and inverted
// polarity) share one stimulus stream; a reference model computes expected
// pins from elapsed enabled cycles and the snapshot value.
module tb_seg7_scan_driver;

    localparam int D = 4;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(D)) if0 ();
    seg7_scan_driver_if #(.DIGITS(D)) if1 ();

    seg7_scan_driver #(
        .DIGITS(D), .TICKS_PER_DIGIT(T),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(if0)
    );

    seg7_scan_driver #(
        .DIGITS(D), .TICKS_PER_DIGIT(T),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(if1)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       fr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned snap   = 0;
    int unsigned en_cyc = 0;  // enabled cycles since reset

    function automatic logic [6:0] glyph(int unsigned n);
        case (n)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1110011;
            default: return 7'b1001111;
        endcase
    endfunction

    task automatic model_step();
        exp_t e;
        int unsigned idx;
        int unsigned upper;
        e.seg = 7'd0;
        e.dig = 4'd0;
        e.fr  = 1'b0;
        if (rst) begin
            snap   = 0;
            en_cyc = 0;
        end else begin
            if (if0.enable) begin
                idx   = (en_cyc / T) % D;
                upper = snap >> (4 * idx);
                e.seg = (idx > 0 && upper == 0) ? 7'd0 : glyph(upper % 16);
                e.dig = 4'(1 << idx);
                e.fr  = ((en_cyc + 1) % (T * D)) == 0;
                en_cyc++;
            end
            if (if0.load) snap = 32'(if0.bcd_in);
        end
        q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Monitor: every edge yields a registered output word
    initial forever begin
        exp_t e;
        logic [6:0] nseg;
        logic [3:0] ndig;
        @(negedge clk);
        if (q.size() > 0) begin
            e    = q.pop_front();
            nseg = ~e.seg;
            ndig = ~e.dig;
            check("seg_hi",   {1'b0, if0.segments},   {1'b0, e.seg});
            check("dig_hi",   {4'b0, if0.digit_sel},  {4'b0, e.dig});
            check("frame_hi", {7'b0, if0.frame_done}, {7'b0, e.fr});
            check("seg_lo",   {1'b0, if1.segments},   {1'b0, nseg});
            check("dig_lo",   {4'b0, if1.digit_sel},  {4'b0, ndig});
            check("frame_lo", {7'b0, if1.frame_done}, {7'b0, e.fr});
        end
    end

    task automatic drive(input logic r, input logic l, input logic en, input logic [15:0] b,
                         input int n);
        rst        = r;
        if0.load   = l;
        if1.load   = l;
        if0.enable = en;
        if1.enable = en;
        if0.bcd_in = b;
        if1.bcd_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic load_run(input logic [15:0] b, input int n);
        drive(1'b0, 1'b1, 1'b1, b, 1);
        drive(1'b0, 1'b0, 1'b1, b, n);
    endtask

    // Run enabled until the model sits mid-slot on digit 2
    task automatic seek_digit2();
        int k;
        k = 0;
        drive(1'b0, 1'b0, 1'b1, 16'h0, 0);
        while ((en_cyc % (T * D)) != 9 && k < 64) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if ((en_cyc % (T * D)) != 9) begin
            errors++;
            $display("FAIL seek_digit2 actual=%0d required=9", en_cyc % (T * D));
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 16'h0, 0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 2);
        load_run(16'h1234, 40);
        load_run(16'h0050, 20);
        load_run(16'h0000, 20);
        load_run(16'h0A07, 20);
        seek_digit2();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 10);
        drive(1'b0, 1'b0, 1'b1, 16'h0, 20);
        load_run(16'h0008, 20);
        seek_digit2();
        drive(1'b1, 1'b1, 1'b1, 16'h9999, 1);
        drive(1'b0, 1'b0, 1'b1, 16'h0, 20);
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                  ($urandom_range(7) != 0), 16'($urandom), 1);
        end
        drive(1'b0, 1'b0, 1'b1, 16'h0, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
